// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared types and helpers for the bit-serial subtractor.
//   state_t : FSM encoding (S_IDLE / S_RUN / S_DONE). Encoding 2'd3 is unused
//             and must recover to S_IDLE on the next clock.
//   cnt_width(w) : width of the bit counter for a w-bit operand.
//             It is $clog2(w)+1, so the counter never needs to wrap.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_sub_fullsub.sv
// fullsub
//   Single-bit combinational full subtractor: diff = a - b - bin.
//   Ports:
//     a    in  1  minuend bit
//     b    in  1  subtrahend bit
//     bin  in  1  borrow into this bit
//     diff out 1  difference bit
//     bout out 1  borrow out of this bit
module fullsub
  import serial_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when a==b and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// serial_sub
//   Bit-serial W-bit subtractor: diff = a - b - bin, processed LSB first,
//   one bit per clock through a single fullsub cell. A borrow flop links
//   successive bits. Operands arrive on a valid/ready handshake and the
//   result leaves on a second valid/ready handshake.
//
//   Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow
//   output ovf. Without it the port and its logic do not exist.
//
//   Parameters:
//     W          operand/result width, W >= 1
//   Ports:
//     clk        in   1  clock, all state updates on posedge
//     rst        in   1  synchronous active-high reset
//     in_valid   in   1  a/b/bin valid this cycle
//     in_ready   out  1  high only while idle
//     a          in   W  minuend
//     b          in   W  subtrahend
//     bin        in   1  borrow-in applied at bit 0
//     out_valid  out  1  result valid (held until out_ready)
//     out_ready  in   1  consumer takes the result
//     diff       out  W  a - b - bin modulo 2^W
//     bout       out  1  borrow out of bit W-1
//     ovf        out  1  signed overflow (SERIAL_SUB_OVF_EN only)
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int             CW       = cnt_width(W);
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

  state_t         state_q,     state_d;
  logic [CW-1:0]  cnt_q,       cnt_d;
  logic [W-1:0]   a_sr_q,      a_sr_d;
  logic [W-1:0]   b_sr_q,      b_sr_d;
  logic           br_q,        br_d;
  logic [W-1:0]   diff_q,      diff_d;
  logic           bout_q,      bout_d;
  logic           in_ready_q,  in_ready_d;
  logic           out_valid_q, out_valid_d;
`ifdef SERIAL_SUB_OVF_EN
  logic           ovf_q,       ovf_d;
`endif

  // The one arithmetic cell; it always looks at the current LSBs and borrow.
  logic cell_d;
  logic cell_nb;

  fullsub u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (br_q),
    .diff (cell_d),
    .bout (cell_nb)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    br_d        = br_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d       = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (in_valid && in_ready_q) begin
          a_sr_d     = a;
          b_sr_d     = b;
          br_d       = bin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        // New bit enters at the MSB; after W shifts bit 0 sits at diff[0].
        // Written as shifts so that W=1 needs no special slicing.
        diff_d = (diff_q >> 1) | (W'(cell_d) << (W - 1));
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        br_d   = cell_nb;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          bout_d      = cell_nb;
`ifdef SERIAL_SUB_OVF_EN
          // Borrow into the MSB differing from borrow out of it marks overflow.
          ovf_d       = br_q ^ cell_nb;
`endif
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        // Unused encoding: fall back to idle with clean handshake outputs.
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      br_q        <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      br_q        <= br_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub
//   Bench for serial_sub at W=8 (table of hand-computed vectors plus
//   backpressure and mid-run reset sequences) and at W=3 / W=1 (exhaustive
//   against a reference model). Define SERIAL_SUB_OVF_EN to also check ovf.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // W=8 instance
  logic       in_valid8, in_ready8, out_valid8, out_ready8, bin8, bout8, ovf8;
  logic [7:0] a8, b8, diff8;
  // W=3 instance
  logic       in_valid3, in_ready3, out_valid3, out_ready3, bin3, bout3, ovf3;
  logic [2:0] a3, b3, diff3;
  // W=1 instance
  logic       in_valid1, in_ready1, out_valid1, out_ready1, bin1, bout1, ovf1;
  logic [0:0] a1, b1, diff1;

  serial_sub #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_sub #(.W(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(b3), .bin(bin3), .out_valid(out_valid3), .out_ready(out_ready3),
    .diff(diff3), .bout(bout3)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf3)
`endif
  );

  serial_sub #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Per-width accessors so one transaction task serves all three instances.
  function automatic logic rdy(input int w);
    case (w)
      1:       return in_ready1;
      3:       return in_ready3;
      default: return in_ready8;
    endcase
  endfunction

  function automatic logic vld(input int w);
    case (w)
      1:       return out_valid1;
      3:       return out_valid3;
      default: return out_valid8;
    endcase
  endfunction

  function automatic logic [7:0] dif(input int w);
    case (w)
      1:       return {7'b0, diff1};
      3:       return {5'b0, diff3};
      default: return diff8;
    endcase
  endfunction

  function automatic logic bor(input int w);
    case (w)
      1:       return bout1;
      3:       return bout3;
      default: return bout8;
    endcase
  endfunction

  function automatic logic ovo(input int w);
`ifdef SERIAL_SUB_OVF_EN
    case (w)
      1:       return ovf1;
      3:       return ovf3;
      default: return ovf8;
    endcase
`else
    return (w < 0);
`endif
  endfunction

  task automatic drive(input int w, input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic bi);
    case (w)
      1:       begin in_valid1 = v; a1 = a[0:0]; b1 = b[0:0]; bin1 = bi; end
      3:       begin in_valid3 = v; a3 = a[2:0]; b3 = b[2:0]; bin3 = bi; end
      default: begin in_valid8 = v; a8 = a;      b8 = b;      bin8 = bi; end
    endcase
  endtask

  task automatic set_ordy(input int w, input logic v);
    case (w)
      1:       out_ready1 = v;
      3:       out_ready3 = v;
      default: out_ready8 = v;
    endcase
  endtask

  // One complete transaction; lat = posedges from accept to out_valid.
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bi,
                        output logic [7:0] d, output logic bo, output logic ov,
                        output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!rdy(w) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'b0, rdy(w)}, 32'd1);
    drive(w, 1'b1, a, b, bi);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, 8'h00, 8'h00, 1'b0);
    lat = 0;
    while (!vld(w) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d  = dif(w);
    bo = bor(w);
    ov = ovo(w);
    set_ordy(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ordy(w, 1'b0);
    check("valid_drop", {31'b0, vld(w)}, 32'd0);
    $display("op W=%0d a=%0h b=%0h bin=%0d -> diff=%0h bout=%0d ovf=%0d lat=%0d",
             w, a, b, bi, d, bo, ov, lat);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       bo, ov;
    int         lat, n, sa, sb, r, lo, hi, mask;

    vecs[0] = '{8'h0A, 8'h03, 1'b0, 8'h07, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h0A, 1'b0, 8'hF9, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[6] = '{8'h55, 8'h0F, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[9] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};

    rst = 1'b1;
    foreach (vecs[i]) begin end
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(3, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    out_ready8 = 1'b0; out_ready3 = 1'b0; out_ready1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_in_ready",  {31'b0, in_ready8},  32'd1);
    check("rst_out_valid", {31'b0, out_valid8}, 32'd0);
    check("rst_diff",      {24'b0, diff8},      32'd0);
    check("rst_bout",      {31'b0, bout8},      32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf",       {31'b0, ovf8},       32'd0);
`endif

    // Table-driven W=8 vectors
    for (int i = 0; i < 10; i++) begin
      run_op(8, vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, ov, lat);
      check($sformatf("vec%0d_diff", i), {24'b0, d},  {24'b0, vecs[i].diff});
      check($sformatf("vec%0d_bout", i), {31'b0, bo}, {31'b0, vecs[i].bout});
      check($sformatf("vec%0d_lat", i),  lat,         32'd8);
`ifdef SERIAL_SUB_OVF_EN
      check($sformatf("vec%0d_ovf", i),  {31'b0, ov}, {31'b0, vecs[i].ovf});
`endif
    end

    // Backpressure: result held while out_ready=0, new operands refused
    @(negedge clk);
    drive(8, 1'b1, 8'h20, 8'h01, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    n = 0;
    while (!out_valid8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp_lat", n, 32'd8);
    drive(8, 1'b1, 8'hAA, 8'h11, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_diff",      {24'b0, diff8},      32'h1F);
      check("bp_bout",      {31'b0, bout8},      32'd0);
      check("bp_in_ready",  {31'b0, in_ready8},  32'd0);
      check("bp_out_valid", {31'b0, out_valid8}, 32'd1);
    end
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
    check("bp_release_valid", {31'b0, out_valid8}, 32'd0);
    check("bp_release_ready", {31'b0, in_ready8},  32'd1);
    $display("op W=8 backpressure hold a=20 b=01 diff=%0h", diff8);
    run_op(8, 8'hAA, 8'h11, 1'b1, d, bo, ov, lat);
    check("bp_next_diff", {24'b0, d},  32'h98);
    check("bp_next_bout", {31'b0, bo}, 32'd0);
    check("bp_next_lat",  lat,         32'd8);

    // Reset on RUN cycle 4 aborts the op
    @(negedge clk);
    drive(8, 1'b1, 8'h12, 8'h34, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mrst_out_valid", {31'b0, out_valid8}, 32'd0);
    check("mrst_in_ready",  {31'b0, in_ready8},  32'd1);
    check("mrst_diff",      {24'b0, diff8},      32'd0);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid8) n++;
    end
    check("mrst_no_valid", n, 32'd0);
    $display("op W=8 reset mid-run a=12 b=34 aborted");
    run_op(8, 8'h55, 8'h0F, 1'b0, d, bo, ov, lat);
    check("mrst_next_diff", {24'b0, d}, 32'h46);
    check("mrst_next_lat",  lat,        32'd8);

    // Exhaustive W=3 and W=1 against a reference model
    foreach (vecs[i]) begin end
    for (int wsel = 0; wsel < 2; wsel++) begin
      int w;
      w    = (wsel == 0) ? 3 : 1;
      mask = (1 << w) - 1;
      lo   = -(1 << (w - 1));
      hi   = (1 << (w - 1)) - 1;
      for (int ia = 0; ia <= mask; ia++) begin
        for (int ib = 0; ib <= mask; ib++) begin
          for (int ic = 0; ic < 2; ic++) begin
            run_op(w, 8'(ia), 8'(ib), ic[0], d, bo, ov, lat);
            check($sformatf("w%0d_diff", w), {24'b0, d}, (ia - ib - ic) & mask);
            check($sformatf("w%0d_bout", w), {31'b0, bo}, (ia < ib + ic) ? 32'd1 : 32'd0);
            check($sformatf("w%0d_lat", w),  lat, w);
`ifdef SERIAL_SUB_OVF_EN
            sa = (ia > hi) ? ia - (1 << w) : ia;
            sb = (ib > hi) ? ib - (1 << w) : ib;
            r  = sa - sb - ic;
            check($sformatf("w%0d_ovf", w), {31'b0, ov}, (r < lo || r > hi) ? 32'd1 : 32'd0);
`else
            sa = 0; sb = 0; r = 0;
`endif
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
